// File: rtl/k2_ctrl_pkg.sv
// k2_ctrl_pkg: shared types and default widths for the K2 run/step/load controller.
//   state_t  controller states
//   op_t     host command opcodes carried on cmd_op
package k2_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_INST_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_STEP = 2'd2,
        OP_HALT = 2'd3
    } op_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk, resetn  rising-edge clock, synchronous active-low reset
//   clr          clear to zero (wins over en)
//   en           count one
//   count        current value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/k2_run_ctrl.sv
// k2_run_ctrl: host-facing run/step/load controller for the K2 core.
//   cmd_valid/cmd_ready/cmd_op/cmd_data  host command port (LOAD, RUN, STEP, HALT)
//   pc, bp_en, bp_addr                   core PC and breakpoint setup
//   core_en, core_rst_n                  core clock-enable and reset request
//   imem_we/imem_waddr/imem_wdata        instruction memory write port
//   running, bp_hit, err, cycle_cnt      status
module k2_run_ctrl
    import k2_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INST_W = DEF_INST_W,
    parameter int unsigned DEPTH  = 2 ** ADDR_W,
    parameter int unsigned CYC_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [INST_W-1:0] cmd_data,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              core_en,
    output logic              core_rst_n,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              running,
    output logic              bp_hit,
    output logic              err,
    output logic [CYC_W-1:0]  cycle_cnt
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            step_ret_q;  // state to return to after a STEP
    logic [ADDR_W-1:0] ptr_q;
    logic              bp_skip_q;
    logic              err_q;

    op_t  op;
    logic cmd_acc;
    logic bp_match;
    logic load_start;

    assign op        = op_t'(cmd_op);
    assign cmd_ready = (state_q != STEP);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign bp_match  = bp_en && (pc == bp_addr) && !bp_skip_q;

    // A breakpoint match (with or without a coincident HALT) stalls the core.
    assign core_en = (state_q == STEP) || ((state_q == RUN) && !bp_match);

    // The pointer is always 0 outside LOAD, so a LOAD from IDLE/BREAK writes byte 0.
    assign load_start = cmd_acc && (op == OP_LOAD) && ((state_q == IDLE) || (state_q == BREAK));
    assign imem_we    = cmd_acc && (op == OP_LOAD) &&
                        ((state_q == IDLE) || (state_q == LOAD) || (state_q == BREAK));
    assign imem_waddr = ptr_q;
    assign imem_wdata = cmd_data;

    assign running    = (state_q == RUN);
    assign bp_hit     = (state_q == BREAK);
    assign core_rst_n = (state_q != LOAD);
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            step_ret_q <= IDLE;
            ptr_q      <= '0;
            bp_skip_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // The skipped breakpoint instruction has now executed.
            if (core_en) bp_skip_q <= 1'b0;
            case (state_q)
                IDLE, BREAK: begin
                    if (cmd_acc) begin
                        case (op)
                            OP_LOAD: begin
                                ptr_q   <= ptr_q + ADDR_W'(1);
                                err_q   <= 1'b0;
                                state_q <= LOAD;
                            end
                            OP_RUN: begin
                                bp_skip_q <= (state_q == BREAK);
                                state_q   <= RUN;
                            end
                            OP_STEP: begin
                                step_ret_q <= state_q;
                                state_q    <= STEP;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                LOAD: begin
                    if (cmd_acc) begin
                        case (op)
                            OP_LOAD: begin
                                err_q <= 1'b0;
                                if (ptr_q == LastAddr) begin
                                    ptr_q   <= '0;
                                    state_q <= IDLE;
                                end else begin
                                    ptr_q <= ptr_q + ADDR_W'(1);
                                end
                            end
                            OP_HALT: begin
                                ptr_q   <= '0;
                                state_q <= IDLE;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                RUN: begin
                    if (cmd_acc && (op == OP_HALT)) begin
                        bp_skip_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        if (cmd_acc) err_q <= 1'b1;
                        if (bp_match) state_q <= BREAK;
                    end
                end
                STEP:    state_q <= step_ret_q;
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W (CYC_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (load_start),
        .en     (core_en),
        .count  (cycle_cnt)
    );

endmodule

// File: tb/tb_k2_run_ctrl.sv
// tb_k2_run_ctrl: directed stimulus against k2_run_ctrl with a behavioural reference model
// checked every cycle, plus hand-computed literal checks.
module tb_k2_run_ctrl;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3, M_BRK = 4;

    logic       clk;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] pc;
    logic       bp_en;
    logic [3:0] bp_addr;
    logic       core_en;
    logic       core_rst_n;
    logic       imem_we;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       running;
    logic       bp_hit;
    logic       err;
    logic [15:0] cycle_cnt;

    k2_run_ctrl u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .core_en    (core_en),
        .core_rst_n (core_rst_n),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .running    (running),
        .bp_hit     (bp_hit),
        .err        (err),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state (committed at posedge, evaluated at negedge).
    int         m_mode, m_ret, n_mode, n_ret;
    logic [3:0] m_ptr, n_ptr;
    bit         m_skip, n_skip, m_err, n_err, m_valid, n_valid;
    logic [15:0] m_cnt, n_cnt;
    bit         e_ready, e_en, e_we, m_acc, m_match;

    logic [7:0] mem [16];
    int         we_seen = 0;
    int         rstn_low_seen = 0;

    initial begin
        m_mode = M_IDLE; m_ret = M_IDLE; m_ptr = '0; m_skip = 0; m_err = 0;
        m_cnt = '0; m_valid = 0; e_en = 0;
    end

    always @(negedge clk) begin
        e_ready = (m_mode != M_STEP);
        m_acc   = cmd_valid && e_ready;
        m_match = bp_en && (pc == bp_addr) && !m_skip;
        e_en    = (m_mode == M_STEP) || (m_mode == M_RUN && !m_match);
        e_we    = m_acc && (cmd_op == 2'd0) &&
                  (m_mode == M_IDLE || m_mode == M_LOAD || m_mode == M_BRK);
        if (m_valid) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("core_en", 32'(core_en), 32'(e_en));
            chk("imem_we", 32'(imem_we), 32'(e_we));
            if (e_we) begin
                chk("imem_waddr", 32'(imem_waddr), 32'(m_ptr));
                chk("imem_wdata", 32'(imem_wdata), 32'(cmd_data));
            end
            chk("running", 32'(running), 32'(m_mode == M_RUN));
            chk("bp_hit", 32'(bp_hit), 32'(m_mode == M_BRK));
            chk("core_rst_n", 32'(core_rst_n), 32'(m_mode != M_LOAD));
            chk("err", 32'(err), 32'(m_err));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
        end
        if (imem_we === 1'b1) begin
            mem[imem_waddr] = imem_wdata;
            we_seen++;
        end
        if (core_rst_n === 1'b0) rstn_low_seen++;

        n_mode = m_mode; n_ret = m_ret; n_ptr = m_ptr; n_err = m_err; n_valid = m_valid;
        n_skip = m_skip && !e_en;
        n_cnt  = (e_en && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
        if (!resetn) begin
            n_mode = M_IDLE; n_ret = M_IDLE; n_ptr = '0; n_skip = 0; n_err = 0;
            n_cnt = '0; n_valid = 1;
        end else begin
            if (m_acc) begin
                if (m_mode == M_IDLE || m_mode == M_BRK) begin
                    case (cmd_op)
                        2'd0: begin n_ptr = 4'd1; n_mode = M_LOAD; n_err = 0; n_cnt = '0; end
                        2'd1: begin n_mode = M_RUN; n_skip = (m_mode == M_BRK); end
                        2'd2: begin n_mode = M_STEP; n_ret = m_mode; end
                        default: n_mode = M_IDLE;
                    endcase
                end else if (m_mode == M_LOAD) begin
                    if (cmd_op == 2'd0) begin
                        n_err = 0;
                        n_ptr = m_ptr + 4'd1;
                        if (m_ptr == 4'd15) n_mode = M_IDLE;
                    end else if (cmd_op == 2'd3) begin
                        n_ptr = '0; n_mode = M_IDLE;
                    end else begin
                        n_err = 1;
                    end
                end else if (m_mode == M_RUN) begin
                    if (cmd_op == 2'd3) begin n_mode = M_IDLE; n_skip = 0; end
                    else n_err = 1;
                end
            end
            if (m_mode == M_RUN && m_match && !(m_acc && cmd_op == 2'd3)) n_mode = M_BRK;
            if (m_mode == M_STEP) n_mode = m_ret;
        end
    end

    // Simple core: PC advances on each expected enabled cycle, or is preset by the bench.
    bit         pc_set_req = 0;
    logic [3:0] pc_set_val = '0;
    initial pc = '0;
    always @(posedge clk) begin
        m_mode <= n_mode; m_ret <= n_ret; m_ptr <= n_ptr; m_skip <= n_skip;
        m_err <= n_err; m_cnt <= n_cnt; m_valid <= n_valid;
        if (pc_set_req) pc <= pc_set_val;
        else if (e_en) pc <= pc + 4'd1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    logic [3:0] pc_hold;

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
        bp_en = 1'b0; bp_addr = '0;
        tick(2);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd1);
        resetn = 1'b1;
        tick(1);

        // Full 16-byte load, back to back.
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'(8'h10 + i);
            tick(1);
        end
        cmd_valid = 1'b0;
        tick(1);
        chk("load16_we_count", 32'(we_seen), 32'd16);
        chk("load16_rstn_low", 32'(rstn_low_seen), 32'd15);
        for (int i = 0; i < 16; i++) chk("load16_mem", 32'(mem[i]), 32'(8'h10 + i));
        chk("load16_idle", 32'(core_rst_n), 32'd1);

        // Partial load aborted by HALT; next load restarts at address 0.
        for (int i = 0; i < 5; i++) cmd(2'd0, 8'(8'hA0 + i));
        cmd(2'd3, 8'h00);
        chk("abort_err", 32'(err), 32'd0);
        cmd(2'd0, 8'h55);
        cmd(2'd3, 8'h00);
        chk("abort_mem0", 32'(mem[0]), 32'h55);
        chk("abort_mem4", 32'(mem[4]), 32'hA4);
        chk("abort_mem5", 32'(mem[5]), 32'h15);

        // Run into a breakpoint at PC 6.
        pc_set_req = 1; pc_set_val = 4'd0;
        tick(1);
        pc_set_req = 0;
        bp_en = 1'b1; bp_addr = 4'd6;
        cmd(2'd1, 8'h00);
        tick(10);
        chk("bp_hit", 32'(bp_hit), 32'd1);
        chk("bp_cycles", 32'(cycle_cnt), 32'd6);
        chk("bp_pc", 32'(pc), 32'd6);

        // Resume from BREAK: PC 6 executes once, then breaks on the next visit.
        cmd(2'd1, 8'h00);
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_core_en", 32'(core_en), 32'd1);
        chk("resume_pc", 32'(pc), 32'd6);
        tick(20);
        chk("rebreak_hit", 32'(bp_hit), 32'd1);
        chk("rebreak_cycles", 32'(cycle_cnt), 32'd22);

        // Step out of BREAK.
        cmd(2'd2, 8'h00);
        chk("bstep_ready", 32'(cmd_ready), 32'd0);
        chk("bstep_en", 32'(core_en), 32'd1);
        tick(2);
        chk("bstep_hit", 32'(bp_hit), 32'd1);
        chk("bstep_cycles", 32'(cycle_cnt), 32'd23);
        chk("bstep_pc", 32'(pc), 32'd7);
        cmd(2'd3, 8'h00);

        // Clear the counter with a LOAD, then step three times from IDLE.
        cmd(2'd0, 8'h77);
        cmd(2'd3, 8'h00);
        chk("clr_cycles", 32'(cycle_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cmd(2'd2, 8'h00);
            tick(2);
        end
        chk("step3_cycles", 32'(cycle_cnt), 32'd3);
        chk("step3_pc", 32'(pc), 32'd10);

        // Illegal STEP while running, then HALT racing a breakpoint match.
        bp_en = 1'b0;
        cmd(2'd1, 8'h00);
        tick(3);
        cmd(2'd2, 8'h00);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_running", 32'(running), 32'd1);
        tick(2);
        pc_hold = pc;
        bp_en = 1'b1; bp_addr = pc;
        cmd(2'd3, 8'h00);
        chk("halt_bp_running", 32'(running), 32'd0);
        chk("halt_bp_hit", 32'(bp_hit), 32'd0);
        chk("halt_bp_pc", 32'(pc), 32'(pc_hold));
        cmd(2'd0, 8'h00);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_cycles", 32'(cycle_cnt), 32'd0);
        chk("reload_rst_n", 32'(core_rst_n), 32'd0);
        cmd(2'd3, 8'h00);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/k2_run_ctrl.md
# k2_run_ctrl

Run/step/load controller for the K2 4-bit core. Sits between a host command port and the core. It loads the 16-byte instruction memory, then sequences execution through a core clock-enable: free run, single step, and a PC breakpoint. It also keeps a cycle count of executed instructions.

## Interface
Parameters:
- ADDR_W, 4, instruction address / PC width
- INST_W, 8, instruction width
- DEPTH, 16, instruction memory depth (2**ADDR_W)
- CYC_W, 16, executed-cycle counter width

Ports:
- clk  in  1  single clock; all logic on its rising edge
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  0=LOAD, 1=RUN, 2=STEP, 3=HALT
- cmd_data  in  INST_W  instruction byte for LOAD; ignored otherwise
- pc  in  ADDR_W  current core PC
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- core_en  out  1  core enable (PC, registers advance only when 1)
- core_rst_n  out  1  active-low core reset request, low throughout LOAD
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  INST_W  write data
- running  out  1  1 in RUN
- bp_hit  out  1  1 in BREAK
- err  out  1  sticky: illegal command accepted; cleared by reset or LOAD
- cycle_cnt  out  CYC_W  cycles with core_en=1; saturating

## Operation
- States: IDLE, LOAD, RUN, STEP, BREAK. The reset state is IDLE.
- IDLE:
  - LOAD: writes byte 0 and goes to LOAD.
  - RUN: goes to RUN.
  - STEP: goes to STEP.
  - HALT: no-op.
- LOAD:
  - Each accepted LOAD writes cmd_data to imem_waddr (load pointer), then increments the pointer.
  - The write of address DEPTH-1 wraps the pointer to 0 and returns to IDLE.
  - HALT aborts: pointer to 0, go to IDLE. Bytes already written are kept.
  - RUN or STEP is accepted, dropped, and sets err.
- RUN:
  - core_en = !(bp_en && pc==bp_addr && !bp_skip).
  - On a breakpoint match, core_en=0 that cycle and the next state is BREAK.
  - HALT goes to IDLE. LOAD, RUN and STEP are dropped and set err.
- BREAK: core is paused.
  - RUN sets bp_skip and goes to RUN. bp_skip lets the instruction at bp_addr execute once, then clears after the first core_en=1 cycle.
  - STEP executes one instruction, ignoring the breakpoint, then returns to BREAK.
  - HALT goes to IDLE.
  - LOAD goes to LOAD and writes byte 0.
- STEP: core_en=1 for exactly one cycle, then returns to the originating state (IDLE or BREAK).
- cycle_cnt increments on every cycle with core_en=1. It saturates at 2**CYC_W-1 and clears when a LOAD is accepted from IDLE or BREAK.
- The imem write port is combinational from cmd_data and the load pointer: imem_we = cmd_valid && cmd_ready && (in LOAD, or starting LOAD from IDLE/BREAK) && op==LOAD.

## Timing
- Reset values: state IDLE, load pointer 0, bp_skip 0, core_en 0, core_rst_n 1, imem_we 0, running 0, bp_hit 0, err 0, cycle_cnt 0.
- Reset mid-LOAD or mid-RUN takes effect at the next edge. Memory contents are not reset.
- cmd_ready: 0 in STEP, 1 in all other states. It does not depend on cmd_valid.
- RUN accepted at edge N: core_en can be 1 in cycle N+1, so the first instruction retires at edge N+1.
- STEP accepted at edge N: core_en=1 in cycle N+1 only, cmd_ready=0 in that cycle, and the state is back at edge N+1.
- Breakpoint detection is combinational on pc, with zero latency. BREAK is entered at the edge following the matching cycle.
- core_rst_n is low in every LOAD-state cycle and returns high in the first cycle after LOAD exits.
- HALT arriving in the same cycle as a breakpoint match: HALT wins, the next state is IDLE, and core_en=0 that cycle.

## Structure
- Package k2_ctrl_pkg holds:
  - state_t (IDLE, LOAD, RUN, STEP, BREAK)
  - op_t (OP_LOAD=2'd0, OP_RUN=2'd1, OP_STEP=2'd2, OP_HALT=2'd3)
  - ADDR_W and INST_W defaults
- One sub-module, sat_counter (parameter W; ports clk, resetn, clr, en, count), instantiated for cycle_cnt.
- The FSM, load pointer and bp_skip live in k2_run_ctrl.

## Test plan
- Reset, then 16 LOAD beats 0x10..0x1F → imem_we on 16 cycles with addresses 0..15 and matching data; core_rst_n=0 throughout; state IDLE after the 16th beat; pointer back at 0.
- Load 5 bytes, then HALT → state IDLE, err=0; the next LOAD writes address 0.
- RUN with bp_en=1, bp_addr=6, PC counting from 0 → core_en=1 for exactly 6 cycles; bp_hit=1; cycle_cnt=6.
- From BREAK at PC 6, RUN → the PC 6 instruction executes (core_en=1 with pc=6); running=1; it breaks again the next time pc=6.
- From IDLE, STEP ×3 → core_en pulses 3 times, each one cycle wide; cmd_ready=0 on each pulse cycle; cycle_cnt=3.
- RUN then STEP while running → err=1 and running stays 1. HALT in the same cycle as a breakpoint match → IDLE with bp_hit=0. A later LOAD clears err and cycle_cnt.
